barrel_shift_pipe: RTL
======================

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width; legal values are powers of two, 2 to 64.
REQ-002 The block SHALL have derived parameter SHW = log2(WIDTH), the shift-amount width and the pipeline stage count.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all registers update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the request is present.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the request this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH, the operand.
REQ-008 The block SHALL have port in_shamt, input, SHW, the shift amount, 0 to WIDTH-1.
REQ-009 The block SHALL have port in_dir, input, 1, where 1 = left and 0 = right.
REQ-010 The block SHALL have port in_mode, input, 2, where 00 = logical, 01 = arithmetic, 10 = rotate and 11 = reserved.
REQ-011 The block SHALL have port out_valid, output, 1, meaning the result is present.
REQ-012 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-013 The block SHALL have port out_data, output, WIDTH, the shifted result.
REQ-014 The block SHALL have port out_zero, output, 1, high when out_data == 0, qualified by out_valid.

Function
REQ-015 A transfer SHALL occur on a rising edge when valid and ready are both high on the same side.
REQ-016 The pipeline SHALL have SHW register stages S1..S_SHW; stage k applies shamt bit SHW-k, largest shift first; S_SHW drives out_data, out_zero and out_valid.
REQ-017 Each stage SHALL carry data, the remaining shamt bits, dir, mode and a valid bit.
REQ-018 A stage whose shamt bit is 0 SHALL pass data unchanged.
REQ-019 Logical mode SHALL zero-fill in both directions.
REQ-020 Arithmetic right SHALL fill with the operand MSB captured at acceptance; arithmetic left SHALL equal logical left.
REQ-021 Rotate SHALL wrap the shifted-out bits into the vacated positions, left or right per dir.
REQ-022 Reserved mode 11 SHALL behave exactly as logical.
REQ-023 Composite result SHALL equal a single shift/rotate of in_data by in_shamt; no overflow or carry output exists.
REQ-024 Latency: a request accepted on edge E SHALL present out_valid=1 with its result from edge E+SHW-1; for WIDTH=8 that is E+2. Full throughput is one result per cycle.
REQ-025 Global advance enable adv = !out_valid || out_ready; all stages SHALL shift forward only when adv=1, and in_ready SHALL equal adv (combinational).
REQ-026 When adv=0, every stage SHALL hold; out_data and out_valid SHALL remain stable until taken.
REQ-027 Bubbles SHALL propagate as valid=0 stages; data in invalid stages is don't-care, but out_zero SHALL be 0 whenever out_valid=0.
REQ-028 Results SHALL leave in acceptance order with no loss or duplication under any out_ready pattern.
REQ-029 When a request is accepted and the output is taken on the same edge, both SHALL complete.

Reset
REQ-030 When rst=1, all stage valid bits SHALL clear immediately; out_valid=0, out_zero=0, out_data=0.
REQ-031 While rst=1, in_ready SHALL read 1, but no request is captured.
REQ-032 Reset mid-stream SHALL discard all in-flight requests; the first request after deassertion SHALL obey REQ-024.

Structure
REQ-033 Mode encodings (MODE_LOG, MODE_ARI, MODE_ROT, MODE_RSV) and direction constants SHALL live in shared package barrel_pkg.
REQ-034 One parameterised sub-module, shift_stage, SHALL implement the combinational shift by fixed amount K for all modes and directions; the top SHALL instantiate it SHW times via generate, with registers in the top.

Verification
REQ-035 The bench SHALL cover WIDTH=8, logical left 0x96 shamt 3 -> out_data 0xB0 two edges after acceptance.
REQ-036 The bench SHALL cover WIDTH=8, arithmetic right 0x96 shamt 2 -> 0xE5; logical right same -> 0x25.
REQ-037 The bench SHALL cover WIDTH=8, rotate right 0x96 shamt 1 -> 0x4B; rotate left 0x96 shamt 4 -> 0x69; logical left 0x80 shamt 1 -> 0x00 with out_zero=1.
REQ-038 The bench SHALL cover back-to-back acceptance of 5 requests with out_ready held low 4 cycles -> in_ready falls once out_valid is high, all 5 results appear in order and none is lost.
REQ-039 The bench SHALL cover rst pulse while 2 requests are in flight -> out_valid=0 at once, no stale result later, and a new request returns after 2 edges.
REQ-040 The bench SHALL cover WIDTH=16, logical right 0x8001 shamt 15 -> 0x0001, latency 3 edges, plus a randomised comparison against a reference model.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared encodings for the pipelined barrel shifter: shift modes and direction.
package barrel_pkg;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_stage.sv
// Combinational shift/rotate by a fixed amount K, applied only when en is set.
module shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);

  logic fill;

  always_comb begin
    fill   = (mode == MODE_ARI) && data[WIDTH-1];
    result = data;
    if (en) begin
      if (mode == MODE_ROT) begin
        if (dir == DIR_LEFT) result = {data[WIDTH-K-1:0], data[WIDTH-1 -: K]};
        else                 result = {data[K-1:0], data[WIDTH-1:K]};
      end else begin
        // Arithmetic left is logical left; reserved mode falls through as logical.
        if (dir == DIR_LEFT) result = {data[WIDTH-K-1:0], {K{1'b0}}};
        else                 result = {{K{fill}}, data[WIDTH-1:K]};
      end
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one stage per shift-amount bit, largest shift first,
// with a single global advance enable providing valid/ready backpressure.
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high on the same side; the whole pipe moves together when adv is high.
  logic adv;

  logic [WIDTH-1:0] data_q  [1:SHW];
  logic [SHW-1:0]   shamt_q [1:SHW];
  logic             dir_q   [1:SHW];
  logic [1:0]       mode_q  [1:SHW];
  logic             valid_q [1:SHW];
  logic             zero_q;

  logic [WIDTH-1:0] src_data  [0:SHW-1];
  logic [SHW-1:0]   src_shamt [0:SHW-1];
  logic             src_dir   [0:SHW-1];
  logic [1:0]       src_mode  [0:SHW-1];
  logic             src_valid [0:SHW-1];
  logic [WIDTH-1:0] shifted   [1:SHW];

  assign out_valid = valid_q[SHW];
  assign out_data  = data_q[SHW];
  assign out_zero  = zero_q;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_comb begin
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_dir[0]   = in_dir;
    src_mode[0]  = in_mode;
    src_valid[0] = in_valid;
    for (int i = 1; i < SHW; i++) begin
      src_data[i]  = data_q[i];
      src_shamt[i] = shamt_q[i];
      src_dir[i]   = dir_q[i];
      src_mode[i]  = mode_q[i];
      src_valid[i] = valid_q[i];
    end
  end

  // Stage k consumes shamt bit SHW-k, i.e. a fixed shift of 2**(SHW-k).
  for (genvar k = 1; k <= SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (1 << (SHW - k))
    ) u_stage (
      .data   (src_data[k-1]),
      .en     (src_shamt[k-1][SHW-k]),
      .dir    (src_dir[k-1]),
      .mode   (src_mode[k-1]),
      .result (shifted[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= SHW; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        shamt_q[i] <= '0;
        dir_q[i]   <= 1'b0;
        mode_q[i]  <= MODE_LOG;
      end
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int i = 1; i <= SHW; i++) begin
        valid_q[i] <= src_valid[i-1];
        data_q[i]  <= shifted[i];
        shamt_q[i] <= src_shamt[i-1];
        dir_q[i]   <= src_dir[i-1];
        mode_q[i]  <= src_mode[i-1];
      end
      // Zero flag is registered alongside the result and forced low for bubbles.
      zero_q <= src_valid[SHW-1] && (shifted[SHW] == '0);
    end
  end

endmodule
